// File: rtl/server_rx_checker_if.sv
// AXI-Stream beat channel from the ToR downlink into the server sink.
interface server_rx_checker_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        tready;

  modport master (output tvalid, tdata, tlast, tkeep, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/server_rx_checker.sv
// Server-side packet sink: checks Ethernet header, length and framing of
// timestamp packets, measures one-way latency and keeps running statistics.
module server_rx_checker #(
  parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
  parameter int          P_PKT_LEN     = 128,
  parameter logic [15:0] P_ETH_TYPE    = 16'h0800
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         i_time_stamp,
  server_rx_checker_if.slave  tx_axis,
  output logic                o_result_valid,
  output logic [3:0]          o_err_code,
  output logic [47:0]         o_src_mac,
  output logic [63:0]         o_latency,
  output logic [63:0]         o_max_latency,
  output logic [31:0]         o_pkt_cnt,
  output logic [31:0]         o_err_cnt
);
  localparam int CW = $clog2(P_PKT_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(P_PKT_LEN - 1);
  localparam logic [CW-1:0] PAY_IDX  = CW'(2);

  // err bit positions: {len, user, type, dmac}
  typedef enum logic [2:0] {SYNC, HDR0, HDR1, PAYLOAD, DROP, DONE} state_t;

  state_t          state_q, state_d;
  logic            tready_q;
  logic [CW-1:0]   beat_q, beat_d;
  logic [3:0]      err_q, err_d;
  logic [47:0]     src_q, src_d;
  logic [63:0]     lat_q, lat_d;
  logic            finish;
  logic            acc;
  logic [3:0]      beat_err;

  assign tx_axis.tready = tready_q;
  assign acc      = tx_axis.tvalid & tready_q;
  assign beat_err = {(tx_axis.tkeep != 8'hFF), tx_axis.tuser, 2'b00};

  // Next-state and per-packet accumulation; finish marks the accepted tlast beat
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    src_d   = src_q;
    lat_d   = lat_q;
    finish  = 1'b0;
    case (state_q)
      SYNC: begin
        if (!tx_axis.tvalid || (acc && tx_axis.tlast)) state_d = HDR0;
      end
      // DONE doubles as HDR0 so back-to-back packets need no idle beat
      HDR0, DONE: begin
        state_d = HDR0;
        if (acc) begin
          err_d    = beat_err;
          err_d[0] = (tx_axis.tdata[63:16] != P_MY_PORT_MAC);
          src_d    = {tx_axis.tdata[15:0], 32'h0};
          lat_d    = '0;
          beat_d   = CW'(1);
          state_d  = HDR1;
          if (tx_axis.tlast) begin
            err_d[1] = 1'b1;               // no ethertype ever seen
            err_d[3] = 1'b1;
            state_d  = DONE;
            finish   = 1'b1;
          end
        end
      end
      HDR1: begin
        if (acc) begin
          err_d       = err_q | beat_err;
          err_d[1]    = (tx_axis.tdata[31:16] != P_ETH_TYPE);
          src_d[31:0] = tx_axis.tdata[63:32];
          beat_d      = PAY_IDX;
          state_d     = PAYLOAD;
          if (tx_axis.tlast) begin
            err_d[3] = 1'b1;
            state_d  = DONE;
            finish   = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (acc) begin
          err_d  = err_q | beat_err;
          beat_d = beat_q + CW'(1);
          if (beat_q == PAY_IDX) lat_d = i_time_stamp - tx_axis.tdata;
          if (tx_axis.tlast) begin
            if (beat_q != LAST_IDX) err_d[3] = 1'b1;
            state_d = DONE;
            finish  = 1'b1;
          end else if (beat_q == LAST_IDX) begin
            err_d[3] = 1'b1;               // overrun: swallow until tlast
            state_d  = DROP;
          end
        end
      end
      DROP: begin
        if (acc) begin
          err_d = err_q | beat_err;
          if (tx_axis.tlast) begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State, packet context, and result/statistics registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= SYNC;
      tready_q       <= 1'b0;
      beat_q         <= '0;
      err_q          <= '0;
      src_q          <= '0;
      lat_q          <= '0;
      o_result_valid <= 1'b0;
      o_err_code     <= '0;
      o_src_mac      <= '0;
      o_latency      <= '0;
      o_max_latency  <= '0;
      o_pkt_cnt      <= '0;
      o_err_cnt      <= '0;
    end else begin
      state_q        <= state_d;
      tready_q       <= 1'b1;
      beat_q         <= beat_d;
      err_q          <= err_d;
      src_q          <= src_d;
      lat_q          <= lat_d;
      o_result_valid <= finish;
      if (finish) begin
        o_err_code <= err_d;
        o_src_mac  <= src_d;
        o_latency  <= lat_d;
        if (err_d == 4'b0000) begin
          o_pkt_cnt <= o_pkt_cnt + 32'd1;
          if (lat_d > o_max_latency) o_max_latency <= lat_d;
        end else begin
          o_err_cnt <= o_err_cnt + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_server_rx_checker.sv
// Directed bench for server_rx_checker: table of packet vectors plus
// hand-written reset and back-to-back sequences.
module tb_server_rx_checker;
  localparam logic [47:0] MY  = 48'h8DBC5C4A0001;
  localparam logic [47:0] BAD = 48'h8DBC5C4A0302;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] ts = 64'h1000;
  logic        o_result_valid;
  logic [3:0]  o_err_code;
  logic [47:0] o_src_mac;
  logic [63:0] o_latency, o_max_latency;
  logic [31:0] o_pkt_cnt, o_err_cnt;

  server_rx_checker_if tx_axis();

  server_rx_checker dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_time_stamp(ts), .tx_axis(tx_axis),
    .o_result_valid(o_result_valid), .o_err_code(o_err_code),
    .o_src_mac(o_src_mac), .o_latency(o_latency),
    .o_max_latency(o_max_latency), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  err;
    logic [47:0] src;
    logic [63:0] lat;
    int          cyc;
  } res_t;
  res_t res_q[$];

  // Result monitor, sampled mid-cycle
  always @(negedge i_clk)
    if (o_result_valid === 1'b1)
      res_q.push_back('{err: o_err_code, src: o_src_mac, lat: o_latency, cyc: cyc});

  typedef struct {
    logic [47:0] dmac;
    logic [15:0] et;
    int          last;
    int          ubeat;
    int          kbeat;
    logic [63:0] lat;
    bit          ovr;
    logic [63:0] tsv;
    logic [3:0]  e_err;
    logic [63:0] e_lat;
    int          e_pkt;
    int          e_errc;
    logic [63:0] e_max;
  } vec_t;

  int n_pass = 0, n_total = 0;
  int last_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(logic [47:0] dm, logic [15:0] et, int last, int ub, int kb,
                              logic [63:0] lat, bit ovr, logic [63:0] tsv, logic [3:0] e,
                              logic [63:0] el, int pc, int ec, logic [63:0] mx);
    vec_t v;
    v.dmac = dm; v.et = et; v.last = last; v.ubeat = ub; v.kbeat = kb;
    v.lat = lat; v.ovr = ovr; v.tsv = tsv; v.e_err = e; v.e_lat = el;
    v.e_pkt = pc; v.e_errc = ec; v.e_max = mx;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      tx_axis.tvalid = 1'b0;
      tx_axis.tlast  = 1'b0;
      tx_axis.tuser  = 1'b0;
      tx_axis.tkeep  = 8'hFF;
      i_rst          = 1'b0;
    end
  endtask

  // One beat per cycle; rst_beat >= 0 pulses reset alongside that beat
  task automatic send_pkt(input logic [47:0] dm, input logic [15:0] et, input logic [47:0] src,
                          input int last, input int ub, input int kb, input logic [63:0] lat,
                          input bit ovr, input logic [63:0] tsv, input int rst_beat);
    for (int i = 0; i <= last; i++) begin
      @(negedge i_clk);
      ts = (ovr && i == 2) ? tsv : ts + 64'd1;
      tx_axis.tvalid = 1'b1;
      case (i)
        0:       tx_axis.tdata = {dm, src[47:32]};
        1:       tx_axis.tdata = {src[31:0], et, 16'h0};
        2:       tx_axis.tdata = ts - lat;
        default: tx_axis.tdata = {32'hDA7A0000, 32'(i)};
      endcase
      tx_axis.tlast = (i == last);
      tx_axis.tkeep = (i == kb) ? 8'h0F : 8'hFF;
      tx_axis.tuser = (i == ub);
      i_rst         = (i == rst_beat);
      if (i == last) last_cyc = cyc;
    end
  endtask

  vec_t vecs[12];
  res_t r;
  int   lc1;

  initial begin
    tx_axis.tvalid = 1'b0; tx_axis.tdata = '0; tx_axis.tlast = 1'b0;
    tx_axis.tkeep = 8'hFF; tx_axis.tuser = 1'b0;

    vecs[0]  = mk(MY,  16'h0800, 127, -1, -1,  40, 0, 0, 4'b0000, 40, 1, 0,  40);
    vecs[1]  = mk(BAD, 16'h86DD, 127, -1, -1,  10, 0, 0, 4'b0011, 10, 1, 1,  40);
    vecs[2]  = mk(MY,  16'h0800,  63, -1, -1,  50, 0, 0, 4'b1000, 50, 1, 2,  40);
    vecs[3]  = mk(MY,  16'h0800, 127, 50, -1,  60, 0, 0, 4'b0100, 60, 1, 3,  40);
    vecs[4]  = mk(MY,  16'h0800, 127, -1, 10,  30, 0, 0, 4'b1000, 30, 1, 4,  40);
    vecs[5]  = mk(MY,  16'h0800, 127, -1, -1,   7, 1, 5, 4'b0000,  7, 2, 4,  40);
    vecs[6]  = mk(MY,  16'h0800, 127, -1, -1, 100, 0, 0, 4'b0000,100, 3, 4, 100);
    vecs[7]  = mk(MY,  16'h0800,   1, -1, -1,  33, 0, 0, 4'b1000,  0, 3, 5, 100);
    vecs[8]  = mk(MY,  16'h0800,   0, -1, -1,  33, 0, 0, 4'b1010,  0, 3, 6, 100);
    vecs[9]  = mk(MY,  16'h0800,   2, -1, -1,   9, 0, 0, 4'b1000,  9, 3, 7, 100);
    vecs[10] = mk(MY,  16'h0800, 140, -1, -1,  20, 0, 0, 4'b1000, 20, 3, 8, 100);
    vecs[11] = mk(MY,  16'h0800, 127, -1, -1,  70, 0, 0, 4'b0000, 70, 4, 8, 100);

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_valid",  64'(o_result_valid), 64'd0);
    chk("rst_tready", 64'(tx_axis.tready), 64'd0);
    chk("rst_pkt",    64'(o_pkt_cnt), 64'd0);
    chk("rst_errc",   64'(o_err_cnt), 64'd0);
    chk("rst_max",    o_max_latency, 64'd0);
    chk("rst_lat",    o_latency, 64'd0);
    idle(2);
    chk("tready_up",  64'(tx_axis.tready), 64'd1);

    // Table-driven packets
    for (int v = 0; v < 12; v++) begin
      logic [47:0] src, esrc;
      src  = 48'h0A0B0C0D0E00 + 48'(v);
      esrc = (vecs[v].last == 0) ? {src[47:32], 32'h0} : src;
      res_q.delete();
      send_pkt(vecs[v].dmac, vecs[v].et, src, vecs[v].last, vecs[v].ubeat,
               vecs[v].kbeat, vecs[v].lat, vecs[v].ovr, vecs[v].tsv, -1);
      idle(3);
      chk($sformatf("v%0d_nres", v), 64'(res_q.size()), 64'd1);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        chk($sformatf("v%0d_cyc", v), 64'(r.cyc), 64'(last_cyc + 1));
        chk($sformatf("v%0d_err", v), 64'(r.err), 64'(vecs[v].e_err));
        chk($sformatf("v%0d_lat", v), r.lat, vecs[v].e_lat);
        chk($sformatf("v%0d_src", v), 64'(r.src), 64'(esrc));
      end
      chk($sformatf("v%0d_pkt", v),  64'(o_pkt_cnt), 64'(vecs[v].e_pkt));
      chk($sformatf("v%0d_errc", v), 64'(o_err_cnt), 64'(vecs[v].e_errc));
      chk($sformatf("v%0d_max", v),  o_max_latency, vecs[v].e_max);
    end

    // Reset during beat 60 of a packet; tail keeps streaming to tlast
    res_q.delete();
    send_pkt(MY, 16'h0800, 48'h111122223333, 127, -1, -1, 40, 0, 0, 60);
    idle(3);
    chk("mrst_nres", 64'(res_q.size()), 64'd0);
    chk("mrst_pkt",  64'(o_pkt_cnt), 64'd0);
    chk("mrst_errc", 64'(o_err_cnt), 64'd0);
    chk("mrst_max",  o_max_latency, 64'd0);
    send_pkt(MY, 16'h0800, 48'h111122223333, 127, -1, -1, 40, 0, 0, -1);
    idle(3);
    chk("mrst_next_nres", 64'(res_q.size()), 64'd1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      chk("mrst_next_err", 64'(r.err), 64'd0);
    end
    chk("mrst_next_pkt", 64'(o_pkt_cnt), 64'd1);

    // Back-to-back good packets after a fresh reset
    @(negedge i_clk); i_rst = 1'b1;
    idle(2);
    res_q.delete();
    send_pkt(MY, 16'h0800, 48'h444455556666, 127, -1, -1, 40, 0, 0, -1);
    lc1 = last_cyc;
    send_pkt(MY, 16'h0800, 48'h777788889999, 127, -1, -1, 25, 0, 0, -1);
    idle(3);
    chk("b2b_nres", 64'(res_q.size()), 64'd2);
    if (res_q.size() == 2) begin
      r = res_q.pop_front();
      chk("b2b_cyc1", 64'(r.cyc), 64'(lc1 + 1));
      chk("b2b_lat1", r.lat, 64'd40);
      r = res_q.pop_front();
      chk("b2b_cyc2", 64'(r.cyc), 64'(last_cyc + 1));
      chk("b2b_lat2", r.lat, 64'd25);
      chk("b2b_err2", 64'(r.err), 64'd0);
    end
    chk("b2b_pkt",  64'(o_pkt_cnt), 64'd2);
    chk("b2b_errc", 64'(o_err_cnt), 64'd0);
    chk("b2b_max",  o_max_latency, 64'd40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
